// File: rtl/bp_update_queue_pkg.sv
// rtl/bp_update_queue_pkg.sv - shared widths and entry layout for the branch-predictor update queue
package bp_update_queue_pkg;

    localparam int GHR_LEN      = 8;
    localparam int GHR_BITS     = GHR_LEN;
    localparam int BPQ_DEPTH    = 4;
    localparam int BPQ_CNT_W    = 16;

    // Entry word layout: {index, pred}, predicted direction in bit 0.
    localparam int ENT_PRED_BIT = 0;
    localparam int ENT_IDX_LSB  = 1;

    function automatic int ent_width(input int idx_w);
        return idx_w + 1;
    endfunction

endpackage

// File: rtl/bp_update_queue_if.sv
// rtl/bp_update_queue_if.sv - push/resolve/update bundle between ID, EX, the queue and the predictor
interface bp_update_queue_if
    import bp_update_queue_pkg::*;
#(
    parameter int IDX_W = GHR_LEN
) ();

    logic             push_valid;
    logic [IDX_W-1:0] push_index;
    logic             push_pred;
    logic             push_ready;
    logic             res_valid;
    logic             res_take;
    logic             flush;
    logic             upd_wen;
    logic [IDX_W-1:0] upd_windex;
    logic             upd_take;
    logic             mispredict;

    modport master (
        output push_valid, push_index, push_pred, res_valid, res_take, flush,
        input  push_ready, upd_wen, upd_windex, upd_take, mispredict
    );

    modport slave (
        input  push_valid, push_index, push_pred, res_valid, res_take, flush,
        output push_ready, upd_wen, upd_windex, upd_take, mispredict
    );

endinterface

// File: rtl/bpq_fifo.sv
// rtl/bpq_fifo.sv - synchronous circular FIFO with occupancy output and same-cycle push/pop
module bpq_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic [CW-1:0] count,
    output logic          full
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          do_push;
    logic          do_pop;

    // Full is taken from the start-of-cycle count, so a slot freed by a pop
    // in the same cycle cannot be refilled until the next one.
    assign full     = (count == CW'(DEPTH));
    assign do_push  = push && !full && !clear;
    assign do_pop   = pop && (count != '0);
    assign pop_data = mem[head];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= tail;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + 1'b1;
            end
            if (do_pop) begin
                head <= head + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bp_update_queue.sv
// rtl/bp_update_queue.sv - holds predicted branches from ID and drives registered predictor updates on EX resolve
module bp_update_queue
    import bp_update_queue_pkg::*;
#(
    parameter int IDX_W = GHR_LEN,
    parameter int DEPTH = BPQ_DEPTH,
    parameter int CNT_W = BPQ_CNT_W
) (
    input  logic                     clk,
    input  logic                     resetn,
    bp_update_queue_if.slave         bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         branch_cnt,
    output logic [CNT_W-1:0]         mispred_cnt,
    output logic                     err_underflow
);

    localparam int EW = ent_width(IDX_W);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [EW-1:0]    head_ent;
    logic [EW-1:0]    push_ent;
    logic [CW-1:0]    occ;
    logic             full;
    logic             push_acc;
    logic             res_acc;
    logic             res_mis;

    logic             upd_wen_q;
    logic [IDX_W-1:0] upd_windex_q;
    logic             upd_take_q;
    logic             mispredict_q;

    assign push_ent = {bus.push_index, bus.push_pred};
    assign push_acc = bus.push_valid && !full && !bus.flush;
    assign res_acc  = bus.res_valid && (occ != '0);
    assign res_mis  = bus.res_take != head_ent[ENT_PRED_BIT];

    // Flush doubles as the FIFO clear; the pop of the flushing branch is
    // still taken from head_ent in the same cycle.
    bpq_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (bus.flush),
        .push      (push_acc),
        .push_data (push_ent),
        .pop       (res_acc),
        .pop_data  (head_ent),
        .count     (occ),
        .full      (full)
    );

    assign bus.push_ready = !full;
    assign count          = occ;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            upd_wen_q     <= 1'b0;
            upd_windex_q  <= '0;
            upd_take_q    <= 1'b0;
            mispredict_q  <= 1'b0;
            branch_cnt    <= '0;
            mispred_cnt   <= '0;
            err_underflow <= 1'b0;
        end else begin
            upd_wen_q    <= res_acc;
            mispredict_q <= res_acc && res_mis;
            if (res_acc) begin
                upd_windex_q <= head_ent[ENT_IDX_LSB +: IDX_W];
                upd_take_q   <= bus.res_take;
                if (branch_cnt != '1) begin
                    branch_cnt <= branch_cnt + 1'b1;
                end
                if (res_mis && (mispred_cnt != '1)) begin
                    mispred_cnt <= mispred_cnt + 1'b1;
                end
            end
            if (bus.res_valid && (occ == '0)) begin
                err_underflow <= 1'b1;
            end
        end
    end

    assign bus.upd_wen    = upd_wen_q;
    assign bus.upd_windex = upd_windex_q;
    assign bus.upd_take   = upd_take_q;
    assign bus.mispredict = mispredict_q;

endmodule

// File: tb/tb_bp_update_queue.sv
// tb/tb_bp_update_queue.sv - scoreboard bench for bp_update_queue against a queue-based reference model
module tb_bp_update_queue;

    localparam int IDX_W = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    bp_update_queue_if #(.IDX_W(IDX_W)) bus ();

    logic [CW-1:0]    count;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;
    logic             err_underflow;

    bp_update_queue #(
        .IDX_W (IDX_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .bus           (bus),
        .count         (count),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt),
        .err_underflow (err_underflow)
    );

    typedef struct {
        int index;
        int pred;
    } ent_t;

    typedef struct {
        int index;
        int take;
        int mis;
    } upd_t;

    ent_t mq[$];
    upd_t eq[$];
    int   m_bc;
    int   m_mc;
    int   m_uf;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_bc = 0;
        m_mc = 0;
        m_uf = 0;
    endtask

    task automatic check_state();
        check("count", 32'(count), mq.size());
        check("branch_cnt", 32'(branch_cnt), m_bc);
        check("mispred_cnt", 32'(mispred_cnt), m_mc);
        check("err_underflow", 32'(err_underflow), m_uf);
    endtask

    task automatic step(input int pv, input int idx, input int pp,
                        input int rv, input int rt, input int fl);
        ent_t e;
        int   ready;
        @(negedge clk);
        check_state();
        ready = (mq.size() < DEPTH) ? 1 : 0;
        check("push_ready", 32'(bus.push_ready), ready);
        bus.push_valid = pv[0];
        bus.push_index = idx[IDX_W-1:0];
        bus.push_pred  = pp[0];
        bus.res_valid  = rv[0];
        bus.res_take   = rt[0];
        bus.flush      = fl[0];
        if (rv != 0) begin
            if (mq.size() > 0) begin
                e = mq.pop_front();
                eq.push_back('{index: e.index, take: rt, mis: (rt != e.pred) ? 1 : 0});
                if (m_bc < CMAX) m_bc++;
                if (rt != e.pred && m_mc < CMAX) m_mc++;
            end else begin
                m_uf = 1;
            end
        end
        if (pv != 0 && ready != 0 && fl == 0) begin
            mq.push_back('{index: idx & ((1 << IDX_W) - 1), pred: pp});
        end
        if (fl != 0) begin
            mq.delete();
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.push_valid = 1'b0;
        bus.push_index = '0;
        bus.push_pred  = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_take   = 1'b0;
        bus.flush      = 1'b0;
        resetn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Monitor: every update pulse must match the oldest expected update, and
    // an expected update must appear exactly one cycle after its resolve.
    always @(posedge clk) begin
        upd_t u;
        #2;
        if (bus.upd_wen === 1'b1) begin
            if (eq.size() == 0) begin
                check("spurious_upd", 32'(bus.upd_windex), 32'hFFFF_FFFF);
            end else begin
                u = eq.pop_front();
                check("upd_windex", 32'(bus.upd_windex), u.index);
                check("upd_take", 32'(bus.upd_take), u.take);
                check("mispredict", 32'(bus.mispredict), u.mis);
            end
        end else begin
            check("mispredict_idle", 32'(bus.mispredict), 0);
            if (eq.size() != 0) begin
                check("missing_upd", 32'(bus.upd_wen), 1);
                eq.delete();
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.push_valid = 1'b0;
        bus.push_index = '0;
        bus.push_pred  = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_take   = 1'b0;
        bus.flush      = 1'b0;
        model_reset();
        do_reset();
        idle();

        // Basic correct prediction
        step(1, 'h3A, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        idle();
        idle();

        // Ordering, drop on full, mispredicts on 1st and 3rd
        step(1, 1, 1, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0);
        step(1, 3, 1, 0, 0, 0);
        step(1, 4, 0, 0, 0, 0);
        step(1, 5, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
        idle();

        // Simultaneous push/resolve at full then at count 3
        for (int i = 0; i < 4; i++) step(1, 'h10 + i, i & 1, 0, 0, 0);
        step(1, 'h20, 0, 1, 1, 0);
        step(1, 'h21, 1, 1, 1, 0);
        idle();

        // Flush with resolve and push in one cycle, then underflow
        step(1, 'h30, 1, 1, 0, 1);
        idle();
        step(0, 0, 0, 1, 1, 0);
        idle();
        idle();

        // Saturation and pointer wrap
        do_reset();
        idle();
        for (int i = 0; i < 20; i++) begin
            step(1, 'h80 + i, 1, 0, 0, 0);
            step(0, 0, 0, 1, 0, 0);
        end
        idle();

        // Randomized traffic with occasional mid-operation reset
        do_reset();
        for (int n = 0; n < 700; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 9) < 6) ? 1 : 0,
                     int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 1)),
                     ($urandom_range(0, 9) < 5) ? 1 : 0,
                     int'($urandom_range(0, 1)),
                     ($urandom_range(0, 24) == 0) ? 1 : 0);
            end
        end
        idle();
        idle();
        idle();
        check("pending_updates", eq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
